// File: rtl/pkt_arb_pkg.sv
// pkt_arb_pkg: shared defaults, state type and counter sizing for packet_arbiter.
// DROP state exists only when PKT_ARB_LENGTH_LIMIT_EN is defined.
package pkt_arb_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_SRC = 4;
  localparam int DEF_MAX_PKT_LEN = 381;
`ifdef PKT_ARB_LENGTH_LIMIT_EN
  typedef enum logic [1:0] {IDLE, STREAM, DROP} arbState_t;
`else
  typedef enum logic {IDLE, STREAM} arbState_t;
`endif
  function automatic int cntWidth(int maxLen);
    return $clog2(maxLen + 1) > 9 ? $clog2(maxLen + 1) : 9;
  endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: index of the first requester at or after ptr, wrapping modulo NUM_SRC.
module rr_priority_picker #(
  parameter int NUM_SRC = 4,
  parameter int IDW = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     pick,
  output logic               anyReq
);
  always_comb begin
    pick = ptr;
    anyReq = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % NUM_SRC]) begin
        pick = IDW'((int'(ptr) + i) % NUM_SRC);
        anyReq = 1'b1;
      end
  end
endmodule

// File: rtl/packet_arbiter.sv
// packet_arbiter: round-robin packet-level arbiter, zero-latency beat forwarding.
// Define PKT_ARB_LENGTH_LIMIT_EN to truncate packets at MAX_PKT_LEN beats and drop the tail.
module packet_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int MAX_PKT_LEN = DEF_MAX_PKT_LEN,
  localparam int IDW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] srcData,
  input  logic [NUM_SRC-1:0]            srcValid,
  input  logic [NUM_SRC-1:0]            srcLast,
  output logic [NUM_SRC-1:0]            srcReady,
  input  logic                          dstReady,
  output logic [DATA_WIDTH-1:0]         dataOut,
  output logic                          validOut,
  output logic                          lastOut,
  output logic [IDW-1:0]                grantId,
  output logic                          busy,
  output logic                          errTrunc
);
  localparam int CNTW = cntWidth(MAX_PKT_LEN);
  arbState_t state, nextState;
  logic [IDW-1:0] ptr, pickIdx;
  logic [CNTW-1:0] beatCnt;
  logic pickAny, grantValid, grantLast, truncHit, dropping, streaming, xfer;
  logic [DATA_WIDTH-1:0] grantData;
  rr_priority_picker #(.NUM_SRC(NUM_SRC), .IDW(IDW)) picker (
    .req(srcValid),
    .ptr(ptr),
    .pick(pickIdx),
    .anyReq(pickAny)
  );
  assign grantData = srcData[int'(grantId)*DATA_WIDTH +: DATA_WIDTH];
  assign grantValid = srcValid[grantId];
  assign grantLast = srcLast[grantId];
  assign streaming = state == STREAM;
  assign busy = state != IDLE;
`ifdef PKT_ARB_LENGTH_LIMIT_EN
  assign truncHit = beatCnt == CNTW'(MAX_PKT_LEN - 1) && !grantLast;
  assign dropping = state == DROP;
`else
  assign truncHit = 1'b0;
  assign dropping = 1'b0;
  assign errTrunc = 1'b0;
`endif
  always_comb begin
    validOut = streaming && grantValid;
    lastOut = streaming && (grantLast || truncHit);
    dataOut = streaming ? grantData : '0;
    xfer = validOut && dstReady;
    srcReady = '0;
    srcReady[grantId] = streaming ? dstReady : dropping;
    nextState = state;
    if (state == IDLE && pickAny) nextState = STREAM;
`ifdef PKT_ARB_LENGTH_LIMIT_EN
    if (xfer && lastOut) nextState = truncHit ? DROP : IDLE;
`else
    if (xfer && lastOut) nextState = IDLE;
`endif
    if (dropping && grantValid && grantLast) nextState = IDLE;
  end
  // counter saturates rather than wrapping when no length limit is enforced
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      grantId <= '0;
      beatCnt <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && pickAny) grantId <= pickIdx;
      if (state != IDLE && nextState == IDLE) ptr <= grantId == IDW'(NUM_SRC - 1) ? '0 : grantId + 1'b1;
      beatCnt <= xfer && lastOut ? '0 : xfer && !(&beatCnt) ? beatCnt + 1'b1 : beatCnt;
    end
`ifdef PKT_ARB_LENGTH_LIMIT_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) errTrunc <= 1'b0;
    else errTrunc <= xfer && truncHit;
`endif
endmodule
